spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) slave, the far-end counterpart of the team's SPI_Master. Shares the spi_sclk / spi_cs_n / spi_mosi / spi_miso interface.
- Oversamples the SPI pins on sys_clk, deserialises MOSI into data_receive and serialises a buffered data_send onto MISO.
- Sits in peripheral/loopback designs and in the SPI_Master bench as the DUT partner.

Parameters:
DATA_WIDTH, 8, bits per SPI word (MSB first)
SYNC_STAGES, 2, synchroniser flops on spi_sclk/spi_cs_n/spi_mosi (min 2)

Ports:
sys_clk  in  1  system clock; must be >= 8x spi_sclk frequency
sys_reset  in  1  synchronous, active-high reset
spi_sclk  in  1  SPI clock from master
spi_cs_n  in  1  chip select, active low
spi_mosi  in  1  master-out data
spi_miso  out  1  slave-out data (registered)
spi_miso_oe  out  1  MISO output enable; high only while selected
data_send  in  DATA_WIDTH  next word to transmit
send_load  in  1  writes data_send into holding register when send_ready=1
send_ready  out  1  holding register empty
data_receive  out  DATA_WIDTH  last complete received word (held)
rec_done  out  1  one-cycle pulse when data_receive updates
busy  out  1  cs_n (synchronised) low

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, send_ready=1, data_receive=0, rec_done=0, busy=0.
- Reset state: FSM=IDLE, bit_cnt=0, holding register empty.
- Pins pass through SYNC_STAGES flops, plus one previous-value flop for edge detection.
- Pin-to-action latency for every edge is SYNC_STAGES+1 sys_clk.
- FSM IDLE:
  - On cs_n fall: go to SHIFT, spi_miso_oe=1, bit_cnt=0.
  - Tx shifter loads the holding register if full (holding becomes empty), else 0x00 (underrun).
  - spi_miso = shifter MSB.
- FSM SHIFT, sclk rise:
  - Shift mosi into rx shifter LSB; bit_cnt++.
  - At bit_cnt==DATA_WIDTH-1 -> data_receive <= completed word; rec_done=1 for exactly one cycle; bit_cnt wraps to 0.
- FSM SHIFT, sclk fall:
  - bit_cnt!=0 -> tx shifter shifts left, spi_miso = new MSB.
  - bit_cnt==0 (byte boundary) -> reload from holding (or 0x00), so back-to-back words need no cs_n toggle.
- FSM SHIFT, cs_n rise (any bit_cnt): go to IDLE, spi_miso_oe=0, bit_cnt=0.
  - Partial rx word discarded, no rec_done.
  - A partially sent tx word is dropped; holding register untouched.
- Holding register:
  - send_ready = ~full.
  - send_load while send_ready=0 is ignored.
  - send_load in the same cycle as a shifter load: the shifter takes the pre-write holding content (0x00 if empty); the new data stays in holding for the next word. No bypass.
- cs_n edges take priority over sclk edges detected in the same sys_clk.
- sclk edges in IDLE are ignored.
- Reset asserted mid-transfer: everything returns to reset values.
  - After reset release, the block waits for synchronised cs_n=1 before it can leave IDLE.
  - A transfer already in progress at reset release is ignored entirely.
- data_receive holds its value until the next rec_done; no overwrite protection (see option).

Optional Feature:
- SPI_SLAVE_STATUS_EN defined: adds ports status_clear (in, 1), rx_overrun (out, 1), tx_underrun (out, 1).
  - rx_overrun sets sticky when rec_done fires again before status_clear since the previous word.
  - tx_underrun sets sticky when the shifter loads 0x00 because holding was empty.
  - Both flags clear on status_clear or sys_reset; a set event in the same cycle wins over clear.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- spi_pkg: SPI_DATA_W=8 default, SPI_SYNC_STAGES=2, FSM state encoding (ST_IDLE, ST_SHIFT).
- Sub-module spi_pin_sync: SYNC_STAGES synchroniser plus rise/fall pulse outputs for one pin.
  - Instantiated for sclk and cs_n; mosi uses the data output only.

Test Plan:
- Reset: sys_reset=1 for 4 cycles -> all outputs at reset values, send_ready=1.
- Single word: send_load 0x3C, master (sclk = sys_clk/8) sends 0xAA.
  - MISO observed 0x3C MSB first.
  - rec_done single pulse, data_receive=0xAA, send_ready returns 1 after cs_n fall.
- Back-to-back, cs_n held low: preload 0x81, reload 0x7E once send_ready=1; master sends 0x12, 0x34.
  - MISO yields 0x81 then 0x7E; rec_done pulses twice; data_receive 0x12 then 0x34.
- Underrun: no send_load, master sends 0x55 -> MISO all zeros, data_receive=0x55, tx_underrun=1 when enabled.
- Abort: cs_n rises after 5 sclk -> no rec_done, spi_miso_oe=0 within SYNC_STAGES+1 cycles.
  - Next full 0xF0 transfer received correctly.
- Reset mid-transfer: sys_reset pulsed after 3 sclk with cs_n low -> no rec_done for that frame.
  - Next frame after cs_n high then low works (0xC3 received).

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared defaults and FSM state encoding for the SPI slave
package spi_pkg;
  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchroniser for one SPI pin with single-cycle rise/fall pulses
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic pin_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // Chain resets low so a pin already low at reset release never yields a fall edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign pin_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = pin_o & ~prev_q;
  assign fall_o = ~pin_o & prev_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with buffered TX word and held RX word; define SPI_SLAVE_STATUS_EN for sticky overrun/underrun flags
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] data_send,
  input  logic                  send_load,
  output logic                  send_ready,
  output logic [DATA_WIDTH-1:0] data_receive,
  output logic                  rec_done,
  output logic                  busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic                  status_clear,
  output logic                  rx_overrun,
  output logic                  tx_underrun
`endif
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  spi_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-2:0]  rx_q, rx_d;
  logic [DATA_WIDTH-1:0]  rx_word;
  logic [DATA_WIDTH-1:0]  tx_q, tx_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   full_q, full_d;
  logic [DATA_WIDTH-1:0]  data_rx_q, data_rx_d;
  logic                   rec_done_q;
  logic                   armed_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;
  logic                   sclk_rise, sclk_fall;
  logic                   cs_s, cs_rise, cs_fall;
  logic                   sclk_s;
  logic                   rec_ev, load;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(sys_clk), .rst(sys_reset), .pin_i(spi_sclk),
    .pin_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk(sys_clk), .rst(sys_reset), .pin_i(spi_cs_n),
    .pin_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign rx_word = {rx_q, mosi_s};

  // Next-state: cs_n edges outrank sclk edges; sclk edges only matter while shifting
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    hold_d    = hold_q;
    full_d    = full_q;
    data_rx_d = data_rx_q;
    rec_ev    = 1'b0;
    load      = 1'b0;
    if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
        load    = 1'b1;
      end
    end else if (cs_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tx_d    = '0;
    end else if (sclk_rise) begin
      rx_d      = rx_word[DATA_WIDTH-2:0];
      rec_ev    = cnt_q == LAST;
      cnt_d     = rec_ev ? '0 : cnt_q + 1'b1;
      data_rx_d = rec_ev ? rx_word : data_rx_q;
    end else if (sclk_fall) begin
      load = cnt_q == '0;
      tx_d = tx_q << 1;
    end
    if (load) begin
      tx_d   = full_q ? hold_q : '0;
      full_d = 1'b0;
    end
    if (send_load && !full_q) begin
      hold_d = data_send;
      full_d = 1'b1;
    end
  end

  // State register; armed_q blocks a transfer already in progress at reset release
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      data_rx_q  <= '0;
      rec_done_q <= 1'b0;
      armed_q    <= 1'b0;
      mosi_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      data_rx_q  <= data_rx_d;
      rec_done_q <= rec_ev;
      armed_q    <= armed_q | cs_s;
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic pend_q, rx_ovr_q, tx_und_q;
  // Sticky flags: a set event in the same cycle beats status_clear
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      pend_q   <= 1'b0;
      rx_ovr_q <= 1'b0;
      tx_und_q <= 1'b0;
    end else begin
      pend_q   <= rec_ev | (pend_q & ~status_clear);
      rx_ovr_q <= (rec_ev & pend_q) | (rx_ovr_q & ~status_clear);
      tx_und_q <= (load & ~full_q) | (tx_und_q & ~status_clear);
    end
  end
  assign rx_overrun  = rx_ovr_q;
  assign tx_underrun = tx_und_q;
`endif

  assign spi_miso     = tx_q[DATA_WIDTH-1];
  assign spi_miso_oe  = state_q == ST_SHIFT;
  assign send_ready   = ~full_q;
  assign data_receive = data_rx_q;
  assign rec_done     = rec_done_q;
  assign busy         = armed_q & ~cs_s;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: table-driven and randomized frame-level checks of spi_slave against a transaction model
module tb_spi_slave;
  localparam int W = 8;
  logic         sys_clk = 1'b0;
  logic         sys_reset = 1'b1;
  logic         spi_sclk = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         send_load = 1'b0;
  logic [W-1:0] data_send = '0;
  logic         spi_miso, spi_miso_oe, send_ready, rec_done, busy;
  logic [W-1:0] data_receive;
`ifdef SPI_SLAVE_STATUS_EN
  logic         status_clear = 1'b0;
  logic         rx_overrun, tx_underrun;
`endif
  int           vectors = 0;
  int           miscompares = 0;
  int           rec_cnt = 0;
  logic [W-1:0] rec_last = '0;

  typedef struct {
    int           n;
    logic [W-1:0] a, b, mo, em, er;
  } vec_t;
  vec_t tbl[5];

  always #5 sys_clk = ~sys_clk;

  spi_slave dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .data_send(data_send),
    .send_load(send_load), .send_ready(send_ready), .data_receive(data_receive),
    .rec_done(rec_done), .busy(busy)
`ifdef SPI_SLAVE_STATUS_EN
    , .status_clear(status_clear), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
`endif
  );

  always @(negedge sys_clk) if (rec_done) begin
    rec_cnt++;
    rec_last = data_receive;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [W-1:0] d);
    data_send = d;
    send_load = 1'b1;
    tick(1);
    send_load = 1'b0;
  endtask

  task automatic xfer(input logic [W-1:0] mo, output logic [W-1:0] mi);
    for (int i = W - 1; i >= 0; i--) begin
      spi_mosi = mo[i];
      tick(4);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic sclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = 1'($urandom);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
      tick(4);
    end
  endtask

  task automatic apply(input string nm, input int n, input logic [W-1:0] a, b, mo, em, er);
    logic [W-1:0] mi;
    int r0;
    if (n > 0) load_word(a);
    if (n > 1) load_word(b);
    if (n > 0) chk({nm, "_full"}, send_ready, 0);
    r0 = rec_cnt;
    spi_cs_n = 1'b0;
    tick(4);
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_oe"}, spi_miso_oe, 1);
    chk({nm, "_ready"}, send_ready, 1);
    xfer(mo, mi);
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
    chk({nm, "_miso"}, mi, em);
    chk({nm, "_recs"}, rec_cnt - r0, 1);
    chk({nm, "_rx"}, data_receive, er);
    chk({nm, "_rxlog"}, rec_last, er);
    chk({nm, "_oe_off"}, spi_miso_oe, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] mi, a, b, mo;
    int r0, n;
    tbl[0] = '{1, 8'h3C, 8'h00, 8'hAA, 8'h3C, 8'hAA};
    tbl[1] = '{0, 8'h00, 8'h00, 8'h55, 8'h00, 8'h55};
    tbl[2] = '{2, 8'h11, 8'h22, 8'h0F, 8'h11, 8'h0F};
    tbl[3] = '{1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    tbl[4] = '{1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
    tick(4);
    chk("rst_miso", spi_miso, 0);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_ready", send_ready, 1);
    chk("rst_rx", data_receive, 0);
    chk("rst_done", rec_done, 0);
    chk("rst_busy", busy, 0);
`ifdef SPI_SLAVE_STATUS_EN
    chk("rst_ovr", rx_overrun, 0);
    chk("rst_und", tx_underrun, 0);
`endif
    sys_reset = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++)
      apply($sformatf("tbl%0d", i), tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].mo, tbl[i].em, tbl[i].er);
`ifdef SPI_SLAVE_STATUS_EN
    chk("st_und", tx_underrun, 1);
    chk("st_ovr", rx_overrun, 1);
    status_clear = 1'b1;
    tick(1);
    status_clear = 1'b0;
    chk("st_und_clr", tx_underrun, 0);
    chk("st_ovr_clr", rx_overrun, 0);
`endif
    load_word(8'h81);
    r0 = rec_cnt;
    spi_cs_n = 1'b0;
    tick(4);
    chk("b2b_ready", send_ready, 1);
    load_word(8'h7E);
    chk("b2b_full", send_ready, 0);
    xfer(8'h12, mi);
    chk("b2b_miso0", mi, 8'h81);
    chk("b2b_rx0", rec_last, 8'h12);
    chk("b2b_recs0", rec_cnt - r0, 1);
    xfer(8'h34, mi);
    chk("b2b_miso1", mi, 8'h7E);
    chk("b2b_rx1", rec_last, 8'h34);
    chk("b2b_recs1", rec_cnt - r0, 2);
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
    chk("b2b_oe_off", spi_miso_oe, 0);
    spi_cs_n = 1'b0;
    tick(2);
    load_word(8'h99);
    chk("same_full", send_ready, 0);
    tick(1);
    xfer(8'h01, mi);
    chk("same_miso0", mi, 8'h00);
    xfer(8'h02, mi);
    chk("same_miso1", mi, 8'h99);
    chk("same_rx", data_receive, 8'h02);
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
    load_word(8'hA5);
    r0 = rec_cnt;
    spi_cs_n = 1'b0;
    tick(4);
    sclk_pulses(5);
    spi_cs_n = 1'b1;
    tick(2);
    chk("abort_oe_hold", spi_miso_oe, 1);
    tick(1);
    chk("abort_oe_off", spi_miso_oe, 0);
    chk("abort_recs", rec_cnt - r0, 0);
    chk("abort_ready", send_ready, 1);
    tick(4);
    apply("after_abort", 1, 8'h5A, 8'h00, 8'hF0, 8'h5A, 8'hF0);
    r0 = rec_cnt;
    spi_cs_n = 1'b0;
    tick(4);
    sclk_pulses(3);
    sys_reset = 1'b1;
    tick(2);
    sys_reset = 1'b0;
    tick(4);
    chk("mid_rst_oe", spi_miso_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx", data_receive, 0);
    sclk_pulses(8);
    chk("mid_rst_recs", rec_cnt - r0, 0);
    chk("mid_rst_oe2", spi_miso_oe, 0);
    spi_cs_n = 1'b1;
    tick(6);
    apply("after_rst", 0, 8'h00, 8'h00, 8'hC3, 8'h00, 8'hC3);
    for (int k = 0; k < 20; k++) begin
      n  = $urandom_range(0, 2);
      a  = W'($urandom);
      b  = W'($urandom);
      mo = W'($urandom);
      apply($sformatf("rnd%0d", k), n, a, b, mo, (n > 0) ? a : '0, mo);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
